jpeg_fb_writer: RTL and testbench



---
 rtl/jpeg_fb_writer_if.sv | 31 +++
 rtl/jpeg_fb_writer.sv | 213 +++++++++++++++++++++
 tb/tb_jpeg_fb_writer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_fb_writer_if.sv
// rtl/jpeg_fb_writer_if.sv - pixel-in / framebuffer-write bundle for jpeg_fb_writer
interface jpeg_fb_writer_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              in_valid_i;
  logic [15:0]       in_width_i;
  logic [15:0]       in_height_i;
  logic [15:0]       in_x_i;
  logic [15:0]       in_y_i;
  logic [7:0]        in_r_i;
  logic [7:0]        in_g_i;
  logic [7:0]        in_b_i;
  logic              in_accept_o;
  logic              wr_valid_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;
  logic [3:0]        wr_strb_o;
  logic              wr_ready_i;

  modport slave (
    input  in_valid_i, in_width_i, in_height_i, in_x_i, in_y_i,
    input  in_r_i, in_g_i, in_b_i, wr_ready_i,
    output in_accept_o, wr_valid_o, wr_addr_o, wr_data_o, wr_strb_o
  );

  modport master (
    output in_valid_i, in_width_i, in_height_i, in_x_i, in_y_i,
    output in_r_i, in_g_i, in_b_i, wr_ready_i,
    input  in_accept_o, wr_valid_o, wr_addr_o, wr_data_o, wr_strb_o
  );
endinterface

// File: rtl/jpeg_fb_writer.sv
// rtl/jpeg_fb_writer.sv - decoded pixel stream to framebuffer write converter
// Two-stage pipe (S1: row multiply and crop, OUT: address and format) plus frame-completion FSM.
module jpeg_fb_writer #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       PIX_FMT   = 0
) (
  input  logic            clk,
  input  logic            reset,
  jpeg_fb_writer_if.slave px,
  output logic            frame_done_o,
  output logic            busy_o,
  output logic [15:0]     crop_count_o,
  output logic            geom_err_o
);
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic              s1_valid_q, s1_valid_d;
  logic [15:0]       s1_x_q, s1_x_d;
  logic [7:0]        s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
  logic [31:0]       s1_prod_q, s1_prod_d;
  logic              s1_crop_q, s1_crop_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [3:0]        wr_strb_q, wr_strb_d;
  logic [15:0]       w_q, w_d, h_q, h_d;
  logic [31:0]       target_q, target_d, wcnt_q, wcnt_d;
  logic [15:0]       crop_cnt_q, crop_cnt_d;
  logic              start_pend_q, start_pend_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              geom_err_q, geom_err_d;

  logic              en, accept, hs, use_latched, in_bounds, start_ok;
  logic [15:0]       w_used, h_used;
  logic [ADDR_W-1:0] lin_idx, out_addr;
  logic [31:0]       out_data;
  logic [3:0]        out_strb;
  logic [15:0]       pix565;

  assign en     = !wr_valid_q | px.wr_ready_i;
  assign accept = en & px.in_valid_i;
  assign hs     = wr_valid_q & px.wr_ready_i;

  // Latched geometry applies once a frame is running or armed by a pixel taken in DONE.
  assign use_latched = (state_q == ST_ACTIVE) | start_pend_q;
  assign w_used      = use_latched ? w_q : px.in_width_i;
  assign h_used      = use_latched ? h_q : px.in_height_i;
  assign in_bounds   = (px.in_x_i < w_used) & (px.in_y_i < h_used);
  // Zero width/height makes in_bounds false, so such pixels are cropped and never start a frame.
  assign start_ok    = accept & in_bounds & !use_latched;

  always_comb begin
    lin_idx = ADDR_W'(s1_prod_q) + ADDR_W'(s1_x_q);
    pix565  = {s1_r_q[7:3], s1_g_q[7:2], s1_b_q[7:3]};
    if (PIX_FMT == 1) begin
      out_addr = BASE_ADDR + (lin_idx << 1);
      out_strb = out_addr[1] ? 4'b1100 : 4'b0011;
      out_data = out_addr[1] ? {pix565, 16'h0000} : {16'h0000, pix565};
    end else begin
      out_addr = BASE_ADDR + (lin_idx << 2);
      out_strb = 4'hF;
      out_data = {8'h00, s1_r_q, s1_g_q, s1_b_q};
    end
  end

  always_comb begin
    state_d      = state_q;
    s1_valid_d   = s1_valid_q;
    s1_x_d       = s1_x_q;
    s1_r_d       = s1_r_q;
    s1_g_d       = s1_g_q;
    s1_b_d       = s1_b_q;
    s1_prod_d    = s1_prod_q;
    s1_crop_d    = s1_crop_q;
    wr_valid_d   = wr_valid_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_strb_d    = wr_strb_q;
    w_d          = w_q;
    h_d          = h_q;
    target_d     = target_q;
    wcnt_d       = wcnt_q;
    crop_cnt_d   = crop_cnt_q;
    start_pend_d = start_pend_q;
    frame_done_d = 1'b0;
    geom_err_d   = geom_err_q;

    if (en) begin
      s1_valid_d = px.in_valid_i;
      if (px.in_valid_i) begin
        s1_x_d    = px.in_x_i;
        s1_r_d    = px.in_r_i;
        s1_g_d    = px.in_g_i;
        s1_b_d    = px.in_b_i;
        s1_prod_d = 32'(px.in_y_i) * 32'(w_used);
        s1_crop_d = !in_bounds;
      end
      wr_valid_d = s1_valid_q & !s1_crop_q;
      if (s1_valid_q & !s1_crop_q) begin
        wr_addr_d = out_addr;
        wr_data_d = out_data;
        wr_strb_d = out_strb;
      end
      if (s1_valid_q & s1_crop_q & (crop_cnt_q != 16'hFFFF)) begin
        crop_cnt_d = crop_cnt_q + 16'd1;
      end
    end

    // Frame start overrides any crop increment from a pixel belonging to the previous frame.
    case (state_q)
      ST_IDLE: begin
        if (start_pend_q) begin
          state_d      = ST_ACTIVE;
          start_pend_d = 1'b0;
        end else if (start_ok) begin
          state_d    = ST_ACTIVE;
          w_d        = px.in_width_i;
          h_d        = px.in_height_i;
          target_d   = 32'(px.in_width_i) * 32'(px.in_height_i);
          wcnt_d     = 32'd0;
          crop_cnt_d = 16'd0;
        end
      end
      ST_ACTIVE: begin
        if (accept & ((px.in_width_i != w_q) | (px.in_height_i != h_q))) begin
          geom_err_d = 1'b1;
        end
        if (hs) begin
          wcnt_d = wcnt_q + 32'd1;
        end
        if (wcnt_d == target_q) begin
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (start_ok) begin
          start_pend_d = 1'b1;
          w_d          = px.in_width_i;
          h_d          = px.in_height_i;
          target_d     = 32'(px.in_width_i) * 32'(px.in_height_i);
          wcnt_d       = 32'd0;
          crop_cnt_d   = 16'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) | s1_valid_d | wr_valid_d | start_pend_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      s1_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_r_q       <= '0;
      s1_g_q       <= '0;
      s1_b_q       <= '0;
      s1_prod_q    <= '0;
      s1_crop_q    <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_strb_q    <= '0;
      w_q          <= '0;
      h_q          <= '0;
      target_q     <= '0;
      wcnt_q       <= '0;
      crop_cnt_q   <= '0;
      start_pend_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      geom_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_valid_q   <= s1_valid_d;
      s1_x_q       <= s1_x_d;
      s1_r_q       <= s1_r_d;
      s1_g_q       <= s1_g_d;
      s1_b_q       <= s1_b_d;
      s1_prod_q    <= s1_prod_d;
      s1_crop_q    <= s1_crop_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_strb_q    <= wr_strb_d;
      w_q          <= w_d;
      h_q          <= h_d;
      target_q     <= target_d;
      wcnt_q       <= wcnt_d;
      crop_cnt_q   <= crop_cnt_d;
      start_pend_q <= start_pend_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      geom_err_q   <= geom_err_d;
    end
  end

  assign px.in_accept_o = en;
  assign px.wr_valid_o  = wr_valid_q;
  assign px.wr_addr_o   = wr_addr_q;
  assign px.wr_data_o   = wr_data_q;
  assign px.wr_strb_o   = wr_strb_q;
  assign frame_done_o   = frame_done_q;
  assign busy_o         = busy_q;
  assign crop_count_o   = crop_cnt_q;
  assign geom_err_o     = geom_err_q;
endmodule

// File: tb/tb_jpeg_fb_writer.sv
// tb/tb_jpeg_fb_writer.sv - self-checking bench for jpeg_fb_writer (RGB888 and RGB565 instances)
module tb_jpeg_fb_writer;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  typedef struct {
    int          x;
    int          y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    bit          exp_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_done, busy, geom_err;
  logic [15:0] crop;
  logic        frame_done5, busy5, geom_err5;
  logic [15:0] crop5;

  jpeg_fb_writer_if #(.ADDR_W(32)) bus ();
  jpeg_fb_writer_if #(.ADDR_W(32)) bus5 ();

  jpeg_fb_writer #(.ADDR_W(32), .BASE_ADDR(32'h1000), .PIX_FMT(0)) u_dut (
    .clk(clk), .reset(reset), .px(bus), .frame_done_o(frame_done),
    .busy_o(busy), .crop_count_o(crop), .geom_err_o(geom_err)
  );

  jpeg_fb_writer #(.ADDR_W(32), .BASE_ADDR(32'h2000), .PIX_FMT(1)) u_dut5 (
    .clk(clk), .reset(reset), .px(bus5), .frame_done_o(frame_done5),
    .busy_o(busy5), .crop_count_o(crop5), .geom_err_o(geom_err5)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  wr_t         q888[$];
  wr_t         q565[$];
  logic [31:0] hs_addr[$];
  int          hs_count = 0;
  int          hs_base = 0;
  int          done_hs = 0;
  int          n_done = 0;
  int          n_done5 = 0;
  bit          stalled = 1'b0;
  wr_t         st;
  wr_t         e8;
  wr_t         e5;
  vec_t        vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] colour(input int x, input int y);
    return {8'(x * 13 + y), 8'(y * 29 + 5), 8'((x * 3) ^ y)};
  endfunction

  // RGB888 monitor: scoreboard pop, stall stability, frame_done bookkeeping.
  always @(negedge clk) begin
    if (!reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid_held", bus.wr_valid_o, 1);
        check("stall_addr_held", bus.wr_addr_o, st.addr);
        check("stall_data_held", bus.wr_data_o, st.data);
        check("stall_strb_held", bus.wr_strb_o, st.strb);
      end
      if (bus.wr_valid_o && !bus.wr_ready_i) begin
        check("stall_no_accept", bus.in_accept_o, 0);
        stalled = 1'b1;
        st = '{addr: bus.wr_addr_o, data: bus.wr_data_o, strb: bus.wr_strb_o};
      end else begin
        stalled = 1'b0;
      end
      if (bus.wr_valid_o && bus.wr_ready_i) begin
        if (q888.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL w888_extra: got write at %0h, required none", bus.wr_addr_o);
        end else begin
          e8 = q888.pop_front();
          check("w888_addr", bus.wr_addr_o, e8.addr);
          check("w888_data", bus.wr_data_o, e8.data);
          check("w888_strb", bus.wr_strb_o, e8.strb);
        end
        hs_addr.push_back(bus.wr_addr_o);
        hs_count++;
      end
      if (frame_done) begin
        n_done++;
        done_hs = hs_count;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (bus5.wr_valid_o && bus5.wr_ready_i) begin
        if (q565.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL w565_extra: got write at %0h, required none", bus5.wr_addr_o);
        end else begin
          e5 = q565.pop_front();
          check("w565_addr", bus5.wr_addr_o, e5.addr);
          check("w565_data", bus5.wr_data_o, e5.data);
          check("w565_strb", bus5.wr_strb_o, e5.strb);
        end
      end
      if (frame_done5) n_done5++;
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that accepted the pixel.
  task automatic send_pixel(input int x, input int y, input int w, input int h,
                            input int ew, input int eh);
    logic [23:0] c;
    bit          got;
    c = colour(x, y);
    bus.in_valid_i  = 1'b1;
    bus.in_x_i      = 16'(x);
    bus.in_y_i      = 16'(y);
    bus.in_width_i  = 16'(w);
    bus.in_height_i = 16'(h);
    {bus.in_r_i, bus.in_g_i, bus.in_b_i} = c;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = bus.in_accept_o;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no accept for (%0d,%0d), required accept", x, y);
    end
    if (x < ew && y < eh) begin
      q888.push_back('{addr: 32'h1000 + 32'((y * ew + x) * 4), data: {8'h00, c}, strb: 4'hF});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = (q888.size() == 0) && !busy && (q565.size() == 0) && !busy5;
    end
    check(name, ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic start_test();
    hs_base = hs_count;
    n_done  = 0;
    hs_addr.delete();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stop_rdy;
    bit seen;
    bus.in_valid_i = 0;  bus.in_width_i = 0; bus.in_height_i = 0; bus.in_x_i = 0; bus.in_y_i = 0;
    bus.in_r_i = 0;      bus.in_g_i = 0;     bus.in_b_i = 0;      bus.wr_ready_i = 1;
    bus5.in_valid_i = 0; bus5.in_width_i = 4; bus5.in_height_i = 2; bus5.in_x_i = 0; bus5.in_y_i = 0;
    bus5.in_r_i = 0;     bus5.in_g_i = 0;     bus5.in_b_i = 0;      bus5.wr_ready_i = 1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    check("rst_wr_valid", bus.wr_valid_o, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_geom_err", geom_err, 0);
    check("rst_crop", crop, 0);
    check("rst_busy", busy, 0);
    check("rst_accept", bus.in_accept_o, 1);

    // RGB565 table on a 4x2 frame; the (5,0) entry is a padding pixel.
    vecs[0] = '{0, 0, 8'hFF, 8'h80, 8'h08, 1, 32'h2000, 32'h0000FC01, 4'b0011};
    vecs[1] = '{1, 0, 8'hFF, 8'h80, 8'h08, 1, 32'h2002, 32'hFC010000, 4'b1100};
    vecs[2] = '{2, 0, 8'h00, 8'hFF, 8'h00, 1, 32'h2004, 32'h000007E0, 4'b0011};
    vecs[3] = '{3, 0, 8'h00, 8'h00, 8'hFF, 1, 32'h2006, 32'h001F0000, 4'b1100};
    vecs[4] = '{5, 0, 8'h12, 8'h34, 8'h56, 0, 32'h0,    32'h0,        4'b0000};
    vecs[5] = '{0, 1, 8'hFF, 8'hFF, 8'hFF, 1, 32'h2008, 32'h0000FFFF, 4'b0011};
    vecs[6] = '{1, 1, 8'h80, 8'h40, 8'h20, 1, 32'h200A, 32'h82040000, 4'b1100};
    vecs[7] = '{2, 1, 8'h07, 8'h03, 8'h07, 1, 32'h200C, 32'h00000000, 4'b0011};
    vecs[8] = '{3, 1, 8'hF8, 8'hFC, 8'hF8, 1, 32'h200E, 32'hFFFF0000, 4'b1100};
    for (int i = 0; i < 9; i++) begin
      bus5.in_valid_i = 1'b1;
      bus5.in_x_i = 16'(vecs[i].x);
      bus5.in_y_i = 16'(vecs[i].y);
      bus5.in_r_i = vecs[i].r;
      bus5.in_g_i = vecs[i].g;
      bus5.in_b_i = vecs[i].b;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge clk);
        seen = bus5.in_accept_o;
      end
      check("v565_accept", seen, 1);
      if (vecs[i].exp_wr) q565.push_back('{addr: vecs[i].addr, data: vecs[i].data, strb: vecs[i].strb});
      @(posedge clk);
      #1;
    end
    bus5.in_valid_i = 1'b0;
    wait_drain("drain_565");
    check("done_565", n_done5, 1);
    check("crop_565", crop5, 1);

    // 16x8 RGB888 raster frame.
    start_test();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) send_pixel(x, y, 16, 8, 16, 8);
    bus.in_valid_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = frame_done;
    end
    check("t1_done_seen", seen, 1);
    @(negedge clk);
    check("t1_busy_drops", busy, 0);
    wait_drain("t1_drain");
    check("t1_done_count", n_done, 1);
    check("t1_done_at", done_hs - hs_base, 128);
    check("t1_addr_3_2", hs_addr[35], 32'h108C);
    check("t1_crop", crop, 0);

    // 10x6 image delivered as a full 16x8 MCU.
    start_test();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) send_pixel(x, y, 10, 6, 10, 6);
    bus.in_valid_i = 1'b0;
    wait_drain("t2_drain");
    check("t2_writes", hs_count - hs_base, 60);
    check("t2_crop", crop, 68);
    check("t2_done_count", n_done, 1);
    check("t2_done_at", done_hs - hs_base, 60);

    // 8x4 frame with random backpressure and continuous input valid.
    start_test();
    stop_rdy = 1'b0;
    fork
      begin
        for (int y = 0; y < 4; y++)
          for (int x = 0; x < 8; x++) send_pixel(x, y, 8, 4, 8, 4);
        bus.in_valid_i = 1'b0;
        stop_rdy = 1'b1;
      end
      begin
        while (!stop_rdy) begin
          @(posedge clk);
          #1;
          bus.wr_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.wr_ready_i = 1'b1;
    wait_drain("t3_drain");
    check("t3_writes", hs_count - hs_base, 32);
    check("t3_done_count", n_done, 1);
    check("t3_done_at", done_hs - hs_base, 32);

    // Width reported as 32 after 5 pixels; addressing keeps the latched 16.
    start_test();
    for (int i = 0; i < 128; i++) begin
      send_pixel(i % 16, i / 16, (i < 5) ? 16 : 32, 8, 16, 8);
      if (i == 4) check("t4_geom_before", geom_err, 0);
    end
    bus.in_valid_i = 1'b0;
    check("t4_geom_set", geom_err, 1);
    wait_drain("t4_drain");
    check("t4_geom_sticky", geom_err, 1);
    check("t4_addr_3_2", hs_addr[35], 32'h108C);
    check("t4_done_count", n_done, 1);
    check("t4_done_at", done_hs - hs_base, 128);

    // Reset while stalled mid-frame, then a full frame.
    start_test();
    for (int i = 0; i < 40; i++) send_pixel(i % 16, i / 16, 16, 8, 16, 8);
    bus.in_valid_i = 1'b0;
    bus.wr_ready_i = 1'b0;
    do_reset();
    q888.delete();
    check("t5_rst_wr_valid", bus.wr_valid_o, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_geom", geom_err, 0);
    check("t5_rst_crop", crop, 0);
    check("t5_rst_accept", bus.in_accept_o, 1);
    check("t5_no_done_first", n_done, 0);
    bus.wr_ready_i = 1'b1;
    start_test();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++) send_pixel(x, y, 16, 8, 16, 8);
    bus.in_valid_i = 1'b0;
    wait_drain("t5_drain");
    check("t5_done_count", n_done, 1);
    check("t5_done_at", done_hs - hs_base, 128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
